// File: rtl/mem_copy_if.sv
// Command/status and memory-port bundle for mem_copy.
// Fill-mode signals exist only when MEM_COPY_FILL_EN is defined.
interface mem_copy_if #(
  parameter int LENW = 16
);
  logic            start;
  logic            abort;
  logic [29:0]     src;
  logic [29:0]     dst;
  logic [LENW-1:0] len;
  logic            busy;
  logic            done;
  logic [LENW-1:0] words_done;
  logic            mem_re;
  logic            mem_we;
  logic [29:0]     memaddr;
  logic [31:0]     rmemdata;
  logic [31:0]     wmemdata;
`ifdef MEM_COPY_FILL_EN
  logic            fill;
  logic [31:0]     fill_data;

  modport master (
    output start, abort, src, dst, len, rmemdata, fill, fill_data,
    input  busy, done, words_done, mem_re, mem_we, memaddr, wmemdata
  );
  modport slave (
    input  start, abort, src, dst, len, rmemdata, fill, fill_data,
    output busy, done, words_done, mem_re, mem_we, memaddr, wmemdata
  );
`else
  modport master (
    output start, abort, src, dst, len, rmemdata,
    input  busy, done, words_done, mem_re, mem_we, memaddr, wmemdata
  );
  modport slave (
    input  start, abort, src, dst, len, rmemdata,
    output busy, done, words_done, mem_re, mem_we, memaddr, wmemdata
  );
`endif
endinterface

// File: rtl/mem_copy.sv
// Word-by-word ascending memory copy engine (READ/WRITE alternation).
// Optional constant-fill mode is built when MEM_COPY_FILL_EN is defined.
module mem_copy #(
  parameter int LENW = 16
) (
  input  logic      clk,
  input  logic      rst,
  mem_copy_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state_reg, state_next;
  logic [29:0]     src_reg, src_next;
  logic [29:0]     dst_reg, dst_next;
  logic [LENW-1:0] len_reg, len_next;
  logic [LENW-1:0] words_done_reg, words_done_next;
  logic [LENW-1:0] count_inc;
  logic            last_word;
  logic            fill_mode;
  logic [31:0]     write_data;

  assign count_inc = words_done_reg + {{(LENW-1){1'b0}}, 1'b1};
  assign last_word = (count_inc == len_reg);

`ifdef MEM_COPY_FILL_EN
  logic        fill_reg, fill_next;
  logic [31:0] fill_data_reg, fill_data_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg      <= 1'b0;
      fill_data_reg <= 32'h0;
    end else begin
      fill_reg      <= fill_next;
      fill_data_reg <= fill_data_next;
    end
  end

  always_comb begin
    fill_next      = fill_reg;
    fill_data_next = fill_data_reg;
    if (state_reg == IDLE && bus.start) begin
      fill_next      = bus.fill;
      fill_data_next = bus.fill_data;
    end
  end

  assign fill_mode  = fill_reg;
  assign write_data = fill_reg ? fill_data_reg : bus.rmemdata;
`else
  assign fill_mode  = 1'b0;
  assign write_data = bus.rmemdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      src_reg        <= 30'h0;
      dst_reg        <= 30'h0;
      len_reg        <= '0;
      words_done_reg <= '0;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      len_reg        <= len_next;
      words_done_reg <= words_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    words_done_next = words_done_reg;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.memaddr     = 30'h0;
    bus.wmemdata    = 32'h0;
    bus.words_done  = words_done_reg;

    case (state_reg)
      IDLE: begin
        bus.busy = 1'b0;
        // abort is deliberately ignored here
        if (bus.start) begin
          src_next        = bus.src;
          dst_next        = bus.dst;
          len_next        = bus.len;
          words_done_next = '0;
          if (bus.len == '0) begin
            state_next = DONE;
          end else begin
`ifdef MEM_COPY_FILL_EN
            state_next = bus.fill ? WRITE : READ;
`else
            state_next = READ;
`endif
          end
        end
      end
      READ: begin
        bus.mem_re  = 1'b1;
        bus.memaddr = src_reg;
        state_next  = bus.abort ? DONE : WRITE;
      end
      WRITE: begin
        bus.mem_we      = 1'b1;
        bus.memaddr     = dst_reg;
        bus.wmemdata    = write_data;
        // the in-flight write always completes and counts, even on abort
        src_next        = src_reg + 30'd1;
        dst_next        = dst_reg + 30'd1;
        words_done_next = count_inc;
        if (bus.abort || last_word) begin
          state_next = DONE;
        end else begin
          state_next = fill_mode ? WRITE : READ;
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_copy.sv
// Directed self-checking bench for mem_copy with a 1-cycle registered memory model.
// Fill-mode vector runs only when MEM_COPY_FILL_EN is defined.
module tb_mem_copy;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_copy_if #(.LENW(16)) bus ();
  mem_copy #(.LENW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [31:0] mem [256];
  always @(posedge clk) bus.rmemdata <= bus.mem_re ? mem[bus.memaddr[7:0]] : 32'h0;

  int tests_run = 0;
  int tests_failed = 0;
  int done_at, n_re, n_we, n_done, n_acc;
  logic [29:0] re_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle 0 edge).
  task automatic run_xfer(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n,
                          input logic ab0, input int abort_at, input int restart_at);
    bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = n; bus.abort = ab0;
    done_at = -1; n_re = 0; n_we = 0; n_done = 0;
    re_log.delete();
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      bus.abort = (c == abort_at);
      if (c == restart_at) begin
        bus.start = 1'b1; bus.src = s + 30'd2; bus.dst = 30'h70; bus.len = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.mem_re) begin n_re++; re_log.push_back(bus.memaddr); end
      if (bus.mem_we) begin n_we++; mem[bus.memaddr[7:0]] = bus.wmemdata; end
      if (bus.done) begin n_done++; if (done_at < 0) done_at = c; end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    $display("[TB] xfer src=0x%08h dst=0x%08h len=%0d: done_at=%0d re=%0d we=%0d done_pulses=%0d words_done=%0d",
             s, d, n, done_at, n_re, n_we, n_done, bus.words_done);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + i;
    for (int i = 4; i < 8; i++) mem[8'h10 + i] = 32'hA0 + i;
    mem[8'hFF] = 32'hB0;
    mem[8'h00] = 32'hB1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
`ifdef MEM_COPY_FILL_EN
    bus.fill = 1'b0; bus.fill_data = 32'h0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
    check_eq("rst_done", {31'h0, bus.done}, 32'h0);
    check_eq("rst_words_done", {16'h0, bus.words_done}, 32'h0);
    check_eq("rst_mem_re", {31'h0, bus.mem_re}, 32'h0);
    rst = 1'b0;

    // Basic copy, started at the first edge after reset, with abort alongside start
    run_xfer(30'h10, 30'h40, 16'd4, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("copy_word%0d", i), mem[8'h40 + i], 32'hA0 + i);
    check_eq("copy_done_cycle", 32'(done_at), 32'd9);
    check_eq("copy_words_done", {16'h0, bus.words_done}, 32'd4);
    check_eq("copy_reads", 32'(n_re), 32'd4);
    check_eq("copy_done_pulses", 32'(n_done), 32'd1);

    // Zero length
    run_xfer(30'h10, 30'h90, 16'd0, 1'b0, 0, 0);
    check_eq("len0_accesses", 32'(n_re + n_we), 32'd0);
    check_eq("len0_done_cycle", 32'(done_at), 32'd1);
    check_eq("len0_words_done", {16'h0, bus.words_done}, 32'd0);

    // Source address wrap
    run_xfer(30'h3FFFFFFF, 30'h20, 16'd2, 1'b0, 0, 0);
    check_eq("wrap_read0", {2'b0, re_log.size() > 0 ? re_log[0] : 30'h1234}, 32'h3FFFFFFF);
    check_eq("wrap_read1", {2'b0, re_log.size() > 1 ? re_log[1] : 30'h1234}, 32'h00000000);
    check_eq("wrap_data0", mem[8'h20], 32'hB0);
    check_eq("wrap_data1", mem[8'h21], 32'hB1);

    // Abort during the third READ (cycle 5) of an 8-word copy
    run_xfer(30'h10, 30'h48, 16'd8, 1'b0, 5, 0);
    check_eq("abort_writes", 32'(n_we), 32'd2);
    check_eq("abort_words_done", {16'h0, bus.words_done}, 32'd2);
    check_eq("abort_done_pulses", 32'(n_done), 32'd1);
    check_eq("abort_done_cycle", 32'(done_at), 32'd6);
    check_eq("abort_no_third", mem[8'h4A], 32'h0);

    // Start while busy is ignored
    run_xfer(30'h10, 30'h60, 16'd2, 1'b0, 0, 2);
    check_eq("busy_start_done_cycle", 32'(done_at), 32'd5);
    check_eq("busy_start_words_done", {16'h0, bus.words_done}, 32'd2);
    check_eq("busy_start_word1", mem[8'h61], 32'hA1);
    check_eq("busy_start_no_write", mem[8'h70], 32'h0);

    // Reset pulsed in the middle of a WRITE cycle
    bus.start = 1'b1; bus.src = 30'h10; bus.dst = 30'h50; bus.len = 16'd8;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("rstmid_pre_we", {31'h0, bus.mem_we}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstmid_we", {31'h0, bus.mem_we}, 32'h0);
    check_eq("rstmid_busy", {31'h0, bus.busy}, 32'h0);
    check_eq("rstmid_memaddr", {2'b0, bus.memaddr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.mem_re || bus.mem_we || bus.busy) n_acc++;
      @(negedge clk);
    end
    check_eq("rstmid_no_access", 32'(n_acc), 32'd0);
    check_eq("rstmid_no_write", mem[8'h50], 32'h0);

`ifdef MEM_COPY_FILL_EN
    bus.fill = 1'b1; bus.fill_data = 32'hDEADBEEF;
    run_xfer(30'h10, 30'h80, 16'd3, 1'b0, 0, 0);
    bus.fill = 1'b0;
    for (int i = 0; i < 3; i++) check_eq($sformatf("fill_word%0d", i), mem[8'h80 + i], 32'hDEADBEEF);
    check_eq("fill_reads", 32'(n_re), 32'd0);
    check_eq("fill_done_cycle", 32'(done_at), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
